// File: rtl/subleq_pkg.sv
// Shared types and constants for the parametrised SUBLEQ core.
package subleq_pkg;

  // Each instruction occupies A, B, C at pc, pc+1, pc+2.
  localparam int INSTR_WORDS = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    FETCH_C,
    READ_A,
    READ_B,
    WRITE_B,
    HALT
  } state_t;

  // All-ones address of the given width; a taken branch here stops the core.
  function automatic logic [63:0] halt_addr(input int aw);
    return (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
  endfunction

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ datapath: mem[B] - mem[A] with the "less than or equal to zero" flag.
module subleq_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] minuend,
  input  logic [DW-1:0] subtrahend,
  output logic [DW-1:0] result,
  output logic          leq
);

  // Wrapping two's-complement subtract; the flag looks only at the wrapped word.
  assign result = minuend - subtrahend;
  assign leq    = result[DW-1] | (result == '0);

endmodule

// File: rtl/subleq_core_param.sv
// Multi-cycle SUBLEQ core with a req/ack memory port, run control, halt
// detection and a saturating retired-instruction counter. Requires DW >= AW.
module subleq_core_param
  import subleq_pkg::*;
#(
  parameter int             DW       = 8,
  parameter int             AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int             CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  output logic [AW-1:0]    pc,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [AW-1:0] HALT_PC = AW'(halt_addr(AW));

  state_t state, state_d;

  logic [AW-1:0]    a_r, b_r, c_r;
  logic [AW-1:0]    a_d, b_d, c_d;
  logic [DW-1:0]    opa_r, opa_d;
  logic             leq_r, leq_d;
  logic             req_d, we_d, halted_d;
  logic [AW-1:0]    addr_d, pc_d;
  logic [DW-1:0]    wdata_d;
  logic [CNT_W-1:0] cnt_d;

  logic [DW-1:0]    alu_res;
  logic             alu_leq;
  logic             adv;
  logic [AW-1:0]    pc_ret;
  logic             halt_hit;

  // mem[A] was latched in READ_A; mem[B] is on the read bus during READ_B.
  subleq_alu #(.DW(DW)) u_alu (
    .minuend    (mem_rdata),
    .subtrahend (opa_r),
    .result     (alu_res),
    .leq        (alu_leq)
  );

  // An ack only counts while a request is outstanding.
  assign adv      = mem_req & mem_ack;
  assign pc_ret   = leq_r ? c_r : pc + AW'(INSTR_WORDS);
  assign halt_hit = leq_r && (c_r == HALT_PC);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next state plus the next value of every registered output, so that the
  // request for a state is already on the port in that state's first cycle.
  always_comb begin
    state_d  = state;
    req_d    = mem_req;
    we_d     = mem_we;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    pc_d     = pc;
    halted_d = halted;
    cnt_d    = instr_count;
    a_d      = a_r;
    b_d      = b_r;
    c_d      = c_r;
    opa_d    = opa_r;
    leq_d    = leq_r;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_d = FETCH_A;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pc;
        end
      end
      FETCH_A: if (adv) begin
        a_d     = mem_rdata[AW-1:0];
        state_d = FETCH_B;
        addr_d  = pc + AW'(1);
      end
      FETCH_B: if (adv) begin
        b_d     = mem_rdata[AW-1:0];
        state_d = FETCH_C;
        addr_d  = pc + AW'(2);
      end
      FETCH_C: if (adv) begin
        c_d     = mem_rdata[AW-1:0];
        state_d = READ_A;
        addr_d  = a_r;
      end
      READ_A: if (adv) begin
        opa_d   = mem_rdata;
        state_d = READ_B;
        addr_d  = b_r;
      end
      READ_B: if (adv) begin
        wdata_d = alu_res;
        leq_d   = alu_leq;
        we_d    = 1'b1;
        state_d = WRITE_B;
      end
      WRITE_B: if (adv) begin
        // Retire: the write has been accepted this cycle.
        cnt_d = (instr_count == '1) ? instr_count : instr_count + CNT_W'(1);
        we_d  = 1'b0;
        if (halt_hit) begin
          state_d  = HALT;
          halted_d = 1'b1;
          pc_d     = HALT_PC;
          req_d    = 1'b0;
        end else begin
          pc_d = pc_ret;
          if (run) begin
            state_d = FETCH_A;
            addr_d  = pc_ret;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Port, pc, counter and instruction registers; reset aborts any transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      instr_count <= '0;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      opa_r       <= '0;
      leq_r       <= 1'b0;
    end else begin
      mem_req     <= req_d;
      mem_we      <= we_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      pc          <= pc_d;
      halted      <= halted_d;
      instr_count <= cnt_d;
      a_r         <= a_d;
      b_r         <= b_d;
      c_r         <= c_d;
      opa_r       <= opa_d;
      leq_r       <= leq_d;
    end
  end

endmodule

// File: tb/tb_subleq_core_param.sv
// Bench for subleq_core_param: directed scenarios plus random programs checked
// against an instruction-level reference model.
module tb_subleq_core_param;
  localparam int DW = 8, AW = 8, CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             run = 1'b0;
  logic             mem_req, mem_we, mem_ack, halted;
  logic [AW-1:0]    mem_addr, pc;
  logic [DW-1:0]    mem_wdata, mem_rdata;
  logic [CNT_W-1:0] instr_count;

  int vecs = 0, errs = 0;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  int         ref_mem [256];
  logic       ld_all = 1'b0;
  logic       stray = 1'b0;
  int         wait_n = 0;
  int         wcnt = 0;

  always #5 clock = ~clock;

  // RAM model: ack after wait_n wait cycles, combinational read data.
  assign mem_ack   = (mem_req && wcnt >= wait_n) || stray;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (ld_all) for (int i = 0; i < 256; i++) mem[i] <= img[i];
    else if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
  end

  subleq_core_param #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .halted(halted), .instr_count(instr_count)
  );

  task automatic set_prog(input int a, input int b, input int c, input int va, input int vb);
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[0] = 8'(a); img[1] = 8'(b); img[2] = 8'(c);
    img[a] = 8'(va); img[b] = 8'(vb);
  endtask

  // Reset the core and load img into the RAM while reset is held.
  task automatic do_reset();
    run = 1'b0; stray = 1'b0; reset_n = 1'b0;
    @(negedge clock); ld_all = 1'b1;
    @(negedge clock); ld_all = 1'b0; reset_n = 1'b1;
  endtask

  // Start one instruction, drop run straight away, wait for it to retire.
  task automatic run_one(output int cycles, output bit unstable);
    int t; logic [CNT_W-1:0] c0; bit pw; logic [AW-1:0] pa; logic pwe; logic [DW-1:0] pd;
    cycles = 0; unstable = 0; t = 0; c0 = instr_count; run = 1'b1;
    while (!mem_req && t < 100) begin @(negedge clock); t++; end
    run = 1'b0;
    while (instr_count == c0 && !halted && t < 1000) begin
      pw = mem_req && !mem_ack; pa = mem_addr; pwe = mem_we; pd = mem_wdata;
      @(negedge clock); cycles++; t++;
      if (pw && mem_req && (mem_addr !== pa || mem_we !== pwe || mem_wdata !== pd)) unstable = 1;
    end
    vecs++; if (t >= 1000) begin errs++; $display("FAIL run_one_timeout cycles=%0d limit=1000", t); end
  endtask

  // Reference: executes whole instructions on ref_mem.
  task automatic model_run(input int k, output int n, output int fpc, output bit fh);
    int p, a, b, c, r;
    p = 0; n = 0; fh = 0;
    while (n < k && !fh) begin
      a = ref_mem[p]; b = ref_mem[(p + 1) % 256]; c = ref_mem[(p + 2) % 256];
      r = (ref_mem[b] - ref_mem[a]) & 255;
      ref_mem[b] = r; n++;
      if (r == 0 || r >= 128) begin
        if (c == 255) begin fh = 1; p = 255; end else p = c;
      end else p = (p + 3) % 256;
    end
    fpc = p;
  endtask

  task automatic test_reset();
    int t;
    set_prog(8'h09, 8'h0A, 8'h06, 8'h03, 8'h05); wait_n = 3;
    reset_n = 1'b0; run = 1'b1;
    @(negedge clock); ld_all = 1'b1; @(negedge clock); ld_all = 1'b0; @(negedge clock);
    vecs++; if (pc !== 8'h00) begin errs++; $display("FAIL rst_pc got %h want 00", pc); end
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL rst_halted got %b want 0", halted); end
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", mem_req); end
    vecs++; if (instr_count !== 16'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", instr_count); end
    reset_n = 1'b1; t = 0;
    while (!(mem_req && mem_addr == 8'h01) && t < 100) begin @(negedge clock); t++; end
    vecs++; if (t >= 100) begin errs++; $display("FAIL rst_reach_fetch_b timeout %0d", t); end
    @(negedge clock);
    reset_n = 1'b0; #1;
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_abort_req got %b want 0", mem_req); end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1; t = 0;
    while (!mem_req && t < 100) begin @(negedge clock); t++; end
    vecs++; if (mem_addr !== 8'h00 || mem_we !== 1'b0) begin
      errs++; $display("FAIL rst_restart got addr=%h we=%b want 00/0", mem_addr, mem_we); end
    run = 1'b0;
  endtask

  task automatic test_positive();
    int cyc; bit u;
    set_prog(8'h09, 8'h0A, 8'h06, 8'h03, 8'h05); wait_n = 0; do_reset(); run_one(cyc, u);
    vecs++; if (cyc != 6) begin errs++; $display("FAIL pos_cycles got %0d want 6", cyc); end
    vecs++; if (mem[8'h0A] !== 8'h02) begin errs++; $display("FAIL pos_mem got %h want 02", mem[8'h0A]); end
    vecs++; if (pc !== 8'h03) begin errs++; $display("FAIL pos_pc got %h want 03", pc); end
    vecs++; if (instr_count !== 16'd1) begin errs++; $display("FAIL pos_cnt got %0d want 1", instr_count); end
  endtask

  task automatic test_branch();
    int cyc; bit u;
    set_prog(8'h09, 8'h0A, 8'h06, 8'h03, 8'h03); wait_n = 0; do_reset(); run_one(cyc, u);
    vecs++; if (mem[8'h0A] !== 8'h00) begin errs++; $display("FAIL br_mem got %h want 00", mem[8'h0A]); end
    vecs++; if (pc !== 8'h06) begin errs++; $display("FAIL br_pc got %h want 06", pc); end
    set_prog(8'h09, 8'h09, 8'h06, 8'h05, 8'h05); do_reset(); run_one(cyc, u);
    vecs++; if (mem[8'h09] !== 8'h00) begin errs++; $display("FAIL aeqb_mem got %h want 00", mem[8'h09]); end
    vecs++; if (pc !== 8'h06) begin errs++; $display("FAIL aeqb_pc got %h want 06", pc); end
  endtask

  task automatic test_wrap();
    int cyc; bit u;
    set_prog(8'h09, 8'h0A, 8'h06, 8'h01, 8'h80); wait_n = 0; do_reset(); run_one(cyc, u);
    vecs++; if (mem[8'h0A] !== 8'h7F) begin errs++; $display("FAIL ovf_mem got %h want 7f", mem[8'h0A]); end
    vecs++; if (pc !== 8'h03) begin errs++; $display("FAIL ovf_pc got %h want 03", pc); end
    // Jump to FE, then an instruction straddling the top of memory (C is mem[00]).
    set_prog(8'h09, 8'h09, 8'hFE, 8'h05, 8'h05);
    img[8'hFE] = 8'h10; img[8'hFF] = 8'h11; img[8'h10] = 8'h01; img[8'h11] = 8'h05;
    do_reset(); run_one(cyc, u);
    vecs++; if (pc !== 8'hFE) begin errs++; $display("FAIL wrap_jump_pc got %h want fe", pc); end
    run_one(cyc, u);
    vecs++; if (pc !== 8'h01) begin errs++; $display("FAIL wrap_pc got %h want 01", pc); end
    vecs++; if (mem[8'h11] !== 8'h04) begin errs++; $display("FAIL wrap_mem got %h want 04", mem[8'h11]); end
    vecs++; if (instr_count !== 16'd2) begin errs++; $display("FAIL wrap_cnt got %0d want 2", instr_count); end
  endtask

  task automatic test_halt();
    int cyc; bit u; bit req_seen;
    set_prog(8'h09, 8'h0A, 8'hFF, 8'h03, 8'h03); wait_n = 1; do_reset(); run_one(cyc, u);
    vecs++; if (mem[8'h0A] !== 8'h00) begin errs++; $display("FAIL halt_write got %h want 00", mem[8'h0A]); end
    vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL halt_flag got %b want 1", halted); end
    vecs++; if (pc !== 8'hFF) begin errs++; $display("FAIL halt_pc got %h want ff", pc); end
    vecs++; if (instr_count !== 16'd1) begin errs++; $display("FAIL halt_cnt got %0d want 1", instr_count); end
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom); stray = 1'($urandom);
      @(negedge clock); if (mem_req) req_seen = 1;
    end
    run = 1'b0; stray = 1'b0;
    vecs++; if (req_seen) begin errs++; $display("FAIL halt_req_quiet got 1 want 0"); end
    vecs++; if (halted !== 1'b1 || pc !== 8'hFF || instr_count !== 16'd1) begin
      errs++; $display("FAIL halt_sticky got h=%b pc=%h cnt=%0d want 1/ff/1", halted, pc, instr_count); end
  endtask

  task automatic test_wait_states();
    int cyc; bit u;
    set_prog(8'h09, 8'h0A, 8'h06, 8'h03, 8'h05); wait_n = 3; do_reset(); run_one(cyc, u);
    vecs++; if (cyc != 24) begin errs++; $display("FAIL wait_cycles got %0d want 24", cyc); end
    vecs++; if (u) begin errs++; $display("FAIL wait_stable got unstable want stable"); end
    vecs++; if (mem[8'h0A] !== 8'h02) begin errs++; $display("FAIL wait_mem got %h want 02", mem[8'h0A]); end
    vecs++; if (pc !== 8'h03) begin errs++; $display("FAIL wait_pc got %h want 03", pc); end
  endtask

  task automatic test_run_drop();
    int cyc; bit u; bit req_seen;
    set_prog(8'h09, 8'h0A, 8'h06, 8'h03, 8'h05);
    img[3] = 8'h0B; img[4] = 8'h0C; img[5] = 8'h20; img[8'h0B] = 8'h02; img[8'h0C] = 8'h07;
    wait_n = 1; do_reset(); run_one(cyc, u);
    req_seen = 0; stray = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge clock); if (mem_req) req_seen = 1; end
    stray = 1'b0;
    vecs++; if (req_seen || pc !== 8'h03 || instr_count !== 16'd1) begin
      errs++; $display("FAIL park_idle got req=%b pc=%h cnt=%0d want 0/03/1", req_seen, pc, instr_count); end
    run_one(cyc, u);
    vecs++; if (cyc != 12) begin errs++; $display("FAIL resume_cycles got %0d want 12", cyc); end
    vecs++; if (mem[8'h0C] !== 8'h05) begin errs++; $display("FAIL resume_mem got %h want 05", mem[8'h0C]); end
    vecs++; if (pc !== 8'h06 || instr_count !== 16'd2) begin
      errs++; $display("FAIL resume_pc got pc=%h cnt=%0d want 06/2", pc, instr_count); end
  endtask

  // Random programs run back to back with run held, stopped after k instructions.
  task automatic test_random();
    int k, w, n, fpc, t, cyc, bad; bit fh;
    for (int trial = 0; trial < 25; trial++) begin
      for (int i = 0; i < 256; i++) begin img[i] = 8'($urandom); ref_mem[i] = int'(img[i]); end
      w = $urandom_range(0, 2); k = $urandom_range(1, 8); wait_n = w;
      do_reset();
      model_run(k, n, fpc, fh);
      run = 1'b1; t = 0;
      while (!mem_req && t < 50) begin @(negedge clock); t++; end
      cyc = 0;
      while (int'(instr_count) < k && !halted && t < 3000) begin
        if (int'(instr_count) == k - 1) run = 1'b0;
        @(negedge clock); cyc++; t++;
      end
      run = 1'b0; repeat (3) @(negedge clock);
      vecs++; if (t >= 3000) begin errs++; $display("FAIL rnd_timeout trial %0d t=%0d", trial, t); end
      vecs++; if (int'(instr_count) != n) begin errs++; $display("FAIL rnd_cnt trial %0d got %0d want %0d", trial, instr_count, n); end
      vecs++; if (int'(pc) != fpc) begin errs++; $display("FAIL rnd_pc trial %0d got %h want %h", trial, pc, fpc); end
      vecs++; if (halted !== fh) begin errs++; $display("FAIL rnd_halt trial %0d got %b want %b", trial, halted, fh); end
      vecs++; if (cyc != n * 6 * (w + 1)) begin errs++; $display("FAIL rnd_cycles trial %0d got %0d want %0d", trial, cyc, n * 6 * (w + 1)); end
      bad = 0;
      for (int i = 0; i < 256; i++) if (int'(mem[i]) != ref_mem[i]) bad++;
      vecs++; if (bad != 0) begin errs++; $display("FAIL rnd_mem trial %0d got %0d differing words want 0", trial, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_branch();
    test_wrap();
    test_halt();
    test_wait_states();
    test_run_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/subleq_core_param.md
Name: subleq_core_param

Overview:
- Parametrised multi-cycle SUBLEQ processor core; next generation of the fixed 8-bit `subleq` core.
- Adds configurable data and address width, a request/acknowledge memory port tolerant of wait states, a run enable, halt detection and a retired-instruction counter.
- Sits between a single-port memory (RAM model on the bench, block RAM on target) and top-level control/status.

Parameters:
- DW, 8, data word width; DW >= AW is required.
- AW, 8, address width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, instr_count width.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- run  in  1  start/continue execution; sampled only in IDLE and at instruction end.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  AW  transaction address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data; valid in the mem_ack cycle.
- mem_ack  in  1  transaction complete; may arrive in the same cycle as mem_req.
- pc  out  AW  address of the current instruction.
- halted  out  1  core stopped on the halt condition.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=RESET_PC.
  - mem_req, mem_we, mem_addr, mem_wdata, halted, instr_count all 0.
  - Internal A/B/C/operand registers cleared.
  - Reset mid-transaction aborts it; mem_req drops immediately.
- Instruction format:
  - Three consecutive words at pc: A, B, C.
  - Operation: mem[B] = mem[B] - mem[A]; if result <= 0 then pc=C, else pc=pc+3.
  - Addresses are the low AW bits of the fetched words.
- FSM states: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, HALT.
  - IDLE: mem_req=0. If run=1, go to FETCH_A next cycle.
  - FETCH_A/B/C: read at pc, pc+1, pc+2 (mod 2^AW); latch into A/B/C on ack.
  - READ_A: read mem[A]. READ_B: read mem[B].
  - WRITE_B: write the result to B.
- Handshake:
  - In every memory state mem_req=1, with mem_addr/mem_we/mem_wdata registered and stable until the ack cycle.
  - The state advances only on a clock edge where mem_ack=1.
  - mem_ack outside mem_req is ignored.
- Arithmetic:
  - DW-bit two's-complement subtraction, wraps on overflow with no flag.
  - leq = result sign bit OR result==0, evaluated on the wrapped DW-bit result.
  - Example: 0x80-0x01 = 0x7F is positive.
- Retirement, on the WRITE_B ack:
  - instr_count increments, saturating at all-ones.
  - pc updates (pc+3 wraps mod 2^AW).
  - If leq and C[AW-1:0] == all-ones: go to HALT; halted=1; pc = all-ones.
  - Else if run=1: go to FETCH_A.
  - Else: go to IDLE.
- HALT:
  - mem_req=0; only reset exits.
  - The halting instruction's write completes before halt.
- run=0 mid-instruction does not abort; the instruction completes.
- Throughput: with zero-wait memory (ack in the request cycle), 6 cycles per instruction. Each wait cycle adds one cycle.
- A == B is legal: the result is 0, taken branch.
- Self-modifying code is legal; a fetch always reads current memory.

Decomposition:
- Package subleq_pkg:
  - state enum.
  - HALT_ADDR function (all-ones of AW).
  - localparam INSTR_WORDS=3.
- One sub-module, subleq_alu (combinational): subtract and leq flag, parametrised by DW.
- FSM, registers and port logic stay in the core.

Test Plan:
- Reset: hold reset_n=0 with run=1 -> pc=0x00, halted=0, mem_req=0, instr_count=0. Assert reset_n=0 mid-FETCH_B with wait states -> mem_req low the same cycle; restart fetches from 0x00.
- Positive result: DW=AW=8, mem[0..2]={09,0A,06}, mem[09]=03, mem[0A]=05, zero-wait ack -> mem[0A]=02, pc=03, instr_count=1 after exactly 6 cycles from leaving IDLE.
- Taken branch: same program, mem[0A]=03 -> mem[0A]=00, pc=06. Separately A=B=09 -> mem[09]=00, pc=06.
- Overflow wrap: mem[09]=01, mem[0A]=80 -> mem[0A]=7F, branch not taken, pc=03. Program at pc=FE with positive result -> pc wraps to 01.
- Halt: C=FF with taken branch -> write occurs, then halted=1, pc=FF, mem_req stays 0 for 20 cycles, run toggling ignored.
- Wait states and run: ack delayed 3 cycles on every transaction -> same results as the positive-result case, mem_addr/mem_we/mem_wdata stable while waiting, instruction takes 24 cycles. Dropping run mid-instruction -> that instruction retires, core parks in IDLE, resumes at the next pc when run=1.
